// File: rtl/interrupt_dispatcher.sv
// Interrupt dispatcher: IE/IF registers, IME with the EI delay, priority
// resolution and the five M-cycle interrupt entry sequence.
module interrupt_dispatcher #(
  parameter int unsigned NUM_IRQ  = 5,
  parameter logic [7:0]  VEC_BASE = 8'h40
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               m_tick,
  input  logic               instr_end,
  input  logic               ie_sel,
  input  logic               if_sel,
  input  logic               WR,
  input  logic               RD,
  input  logic [7:0]         DL_in,
  output logic [7:0]         DL_out,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic               halted,
  output logic               dispatch,
  output logic [2:0]         disp_state,
  output logic [7:0]         int_vector,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic               cpu_wake,
  output logic               ime
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_D1   = 3'd1,
    S_D2   = 3'd2,
    S_D3   = 3'd3,
    S_D4   = 3'd4,
    S_D5   = 3'd5
  } state_t;

  state_t             state_q, state_next;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] if_q, if_next;
  logic               ime_q, ime_pending_q;
  logic               ime_upd, pend_upd, ime_next, pend_next;
  logic [7:0]         int_vector_q;
  logic               cpu_wake_q;

  logic [NUM_IRQ-1:0] pending;
  logic               any_pending;
  logic               boundary, start, resolve, found;
  logic [IDX_W-1:0]   sel_idx;
  logic [7:0]         sel_vector;
  logic [7:0]         if_read;
  logic               wr_ie, wr_if;

  assign pending     = ie_q[NUM_IRQ-1:0] & if_q;
  assign any_pending = |pending;
  assign wr_ie       = WR & ie_sel & m_tick;
  assign wr_if       = WR & if_sel & m_tick;
  assign boundary    = m_tick & instr_end & (state_q == S_IDLE);
  // Winner is chosen at the end of D4 so a late IE/IF change is honoured.
  assign resolve     = (state_q == S_D4) & m_tick & ~RESET;

  // Lowest set pending bit wins; scanning downward leaves the lowest index.
  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise an
    // unassigned path would infer a latch.
    sel_idx = '0;
    found   = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
    sel_vector = VEC_BASE + 8'({sel_idx, 3'b000});
  end

  // Acknowledge is a single-CLK strobe on the resolving m_tick.
  always_comb begin
    int_ack = '0;
    if (resolve && found) begin
      int_ack = {{(NUM_IRQ-1){1'b0}}, 1'b1} << sel_idx;
    end
  end

  // IF next value: ack clear, then CPU write, then peripheral set wins last.
  always_comb begin
    if_next = if_q & ~int_ack;
    if (wr_if) begin
      if_next = DL_in[NUM_IRQ-1:0];
    end
    if_next = if_next | irq_req;
  end

  // IME update at instruction boundaries, then dispatch start overrides it.
  always_comb begin
    ime_upd  = ime_q;
    pend_upd = ime_pending_q;
    if (boundary) begin
      if (di) begin
        ime_upd  = 1'b0;
        pend_upd = 1'b0;
      end else begin
        if (ime_pending_q) begin
          ime_upd  = 1'b1;
          pend_upd = 1'b0;
        end else if (ei) begin
          pend_upd = 1'b1;
        end
        if (reti) begin
          ime_upd = 1'b1;
        end
      end
    end
    start = (state_q == S_IDLE) & any_pending &
            ((boundary & ime_upd) | (m_tick & halted & ime_q));
    ime_next  = start ? 1'b0 : ime_upd;
    pend_next = start ? 1'b0 : pend_upd;
  end

  // Entry sequence: one state per m_tick, off-tick CLKs hold.
  always_comb begin
    state_next = state_q;
    unique case (state_q)
      S_IDLE:  if (start)  state_next = S_D1;
      S_D1:    if (m_tick) state_next = S_D2;
      S_D2:    if (m_tick) state_next = S_D3;
      S_D3:    if (m_tick) state_next = S_D4;
      S_D4:    if (m_tick) state_next = S_D5;
      S_D5:    if (m_tick) state_next = S_IDLE;
      default:             state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values regardless of statement order.
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_next;
  end

  // Interrupt registers, IME, latched vector and wake flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ie_q          <= 8'h00;
      if_q          <= '0;
      ime_q         <= 1'b0;
      ime_pending_q <= 1'b0;
      int_vector_q  <= 8'h00;
      cpu_wake_q    <= 1'b0;
    end else begin
      if (wr_ie) ie_q <= DL_in;
      if_q          <= if_next;
      ime_q         <= ime_next;
      ime_pending_q <= pend_next;
      cpu_wake_q    <= any_pending;
      if (resolve) int_vector_q <= found ? sel_vector : 8'h00;
    end
  end

  // Register read mux; unimplemented IF bits read as 1.
  always_comb begin
    if_read              = 8'hFF;
    if_read[NUM_IRQ-1:0] = if_q;
    DL_out               = 8'h00;
    if (RD && ie_sel)      DL_out = ie_q;
    else if (RD && if_sel) DL_out = if_read;
  end

  assign dispatch   = (state_q != S_IDLE);
  assign disp_state = state_q;
  assign int_vector = int_vector_q;
  assign cpu_wake   = cpu_wake_q;
  assign ime        = ime_q;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Self-checking bench for interrupt_dispatcher: directed vectors, with a
// scoreboard of expected dispatch outcomes checked by a separate monitor.
module tb_interrupt_dispatcher;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       m_tick = 1'b0, instr_end = 1'b0;
  logic       ie_sel = 1'b0, if_sel = 1'b0, WR = 1'b0, RD = 1'b0;
  logic [7:0] DL_in = 8'h00;
  logic [7:0] DL_out;
  logic [4:0] irq_req = 5'b0;
  logic       ei = 1'b0, di = 1'b0, reti = 1'b0, halted = 1'b0;
  logic       dispatch;
  logic [2:0] disp_state;
  logic [7:0] int_vector;
  logic [4:0] int_ack;
  logic       cpu_wake, ime;

  typedef struct {
    logic [4:0] ack;
    logic [7:0] vec;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic       armed = 1'b0;
  logic [4:0] ack_cap = 5'b0;
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rd;

  interrupt_dispatcher #(.NUM_IRQ(5), .VEC_BASE(8'h40)) dut (
    .CLK(CLK), .RESET(RESET), .m_tick(m_tick), .instr_end(instr_end),
    .ie_sel(ie_sel), .if_sel(if_sel), .WR(WR), .RD(RD),
    .DL_in(DL_in), .DL_out(DL_out), .irq_req(irq_req),
    .ei(ei), .di(di), .reti(reti), .halted(halted),
    .dispatch(dispatch), .disp_state(disp_state), .int_vector(int_vector),
    .int_ack(int_ack), .cpu_wake(cpu_wake), .ime(ime)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One M-cycle: an idle CLK, then the m_tick CLK; qualifiers set by the
  // caller apply to the m_tick CLK and are cleared afterwards.
  task automatic mcyc(input logic [4:0] irq_on_tick = 5'b0);
    m_tick = 1'b0;
    tick();
    m_tick  = 1'b1;
    irq_req = irq_on_tick;
    tick();
    m_tick = 1'b0; irq_req = 5'b0; instr_end = 1'b0;
    ei = 1'b0; di = 1'b0; reti = 1'b0;
    WR = 1'b0; ie_sel = 1'b0; if_sel = 1'b0;
  endtask

  task automatic pulse_irq(input logic [4:0] v);
    irq_req = v;
    tick();
    irq_req = 5'b0;
  endtask

  task automatic write_reg(input bit to_ie, input logic [7:0] v);
    WR = 1'b1; ie_sel = to_ie; if_sel = !to_ie; DL_in = v;
    mcyc();
  endtask

  task automatic read_reg(input bit from_ie, output logic [7:0] v);
    RD = 1'b1; ie_sel = from_ie; if_sel = !from_ie;
    #1;
    v = DL_out;
    RD = 1'b0; ie_sel = 1'b0; if_sel = 1'b0;
  endtask

  task automatic instr(input bit do_ei, input bit do_di, input bit do_reti);
    instr_end = 1'b1; ei = do_ei; di = do_di; reti = do_reti;
    mcyc();
  endtask

  // Monitor: capture ack on the m_tick ending D4, compare in D5.
  always @(negedge CLK) begin
    if (RESET) begin
      armed <= 1'b0;
    end else if (m_tick && disp_state == 3'd4) begin
      ack_cap <= int_ack;
      armed   <= 1'b1;
    end else if (armed) begin
      armed <= 1'b0;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dispatch: got vector %0h, expected none", int_vector);
      end else begin
        mon_e = exp_q.pop_front();
        check("int_ack", {27'b0, ack_cap}, {27'b0, mon_e.ack});
        check("int_vector", {24'b0, int_vector}, {24'b0, mon_e.vec});
        check("disp_state_d5", {29'b0, disp_state}, 32'd5);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("rst_dispatch", {31'b0, dispatch}, 32'd0);
    check("rst_state", {29'b0, disp_state}, 32'd0);
    check("rst_ime", {31'b0, ime}, 32'd0);
    check("rst_wake", {31'b0, cpu_wake}, 32'd0);
    check("rst_vector", {24'b0, int_vector}, 32'h00);
    check("rst_ack", {27'b0, int_ack}, 32'd0);
    check("rst_dl_idle", {24'b0, DL_out}, 32'h00);
    read_reg(1, rd); check("rst_ie", {24'b0, rd}, 32'h00);
    read_reg(0, rd); check("rst_if", {24'b0, rd}, 32'hE0);
    RESET = 1'b0;
    tick();

    // Basic dispatch of source 0.
    write_reg(1, 8'h01);
    instr(1, 0, 0);
    check("ei_delay_ime", {31'b0, ime}, 32'd0);
    instr(0, 0, 0);
    check("ei_nop_ime", {31'b0, ime}, 32'd1);
    pulse_irq(5'b00001);
    read_reg(0, rd); check("if_after_irq0", {24'b0, rd}, 32'hE1);
    exp_q.push_back('{ack: 5'b00001, vec: 8'h40});
    instr(0, 0, 0);
    check("start_dispatch", {31'b0, dispatch}, 32'd1);
    check("start_d1", {29'b0, disp_state}, 32'd1);
    check("start_ime_clr", {31'b0, ime}, 32'd0);
    repeat (4) mcyc();
    read_reg(0, rd); check("if_after_ack0", {24'b0, rd}, 32'hE0);
    mcyc();
    check("back_idle", {31'b0, dispatch}, 32'd0);

    // Two simultaneous requests: lower index first, then RETI re-enables.
    write_reg(1, 8'h1F);
    pulse_irq(5'b10100);
    read_reg(0, rd); check("if_two_req", {24'b0, rd}, 32'hF4);
    instr(1, 0, 0);
    exp_q.push_back('{ack: 5'b00100, vec: 8'h50});
    instr(0, 0, 0);
    check("dispatch_two", {31'b0, dispatch}, 32'd1);
    repeat (4) mcyc();
    read_reg(0, rd); check("if_after_ack2", {24'b0, rd}, 32'hF0);
    mcyc();
    exp_q.push_back('{ack: 5'b10000, vec: 8'h60});
    instr(0, 0, 1);
    check("reti_dispatch", {31'b0, dispatch}, 32'd1);
    repeat (5) mcyc();
    read_reg(0, rd); check("if_after_ack4", {24'b0, rd}, 32'hE0);

    // EI then NOP: no dispatch on the EI boundary.
    write_reg(1, 8'h01);
    pulse_irq(5'b00001);
    instr(1, 0, 0);
    check("no_disp_at_ei", {31'b0, dispatch}, 32'd0);
    exp_q.push_back('{ack: 5'b00001, vec: 8'h40});
    instr(0, 0, 0);
    check("disp_at_nop", {31'b0, dispatch}, 32'd1);
    repeat (5) mcyc();
    // DI beats EI; EI;EI enables after the second.
    instr(1, 1, 0);
    instr(0, 0, 0);
    check("di_beats_ei", {31'b0, ime}, 32'd0);
    instr(1, 0, 0);
    instr(1, 0, 0);
    check("ei_ei_ime", {31'b0, ime}, 32'd1);

    // Cancelled dispatch: IE cleared before D4 resolution.
    pulse_irq(5'b00001);
    exp_q.push_back('{ack: 5'b00000, vec: 8'h00});
    instr(0, 0, 0);
    mcyc(); mcyc();
    write_reg(1, 8'h00);
    mcyc();
    read_reg(0, rd); check("if_kept_cancel", {24'b0, rd}, 32'hE1);
    mcyc();

    // HALT wake with ime = 0: wake only, no dispatch.
    write_reg(0, 8'h00);
    write_reg(1, 8'h04);
    halted = 1'b1;
    pulse_irq(5'b00100);
    check("wake_not_yet", {31'b0, cpu_wake}, 32'd0);
    tick();
    check("wake_set", {31'b0, cpu_wake}, 32'd1);
    mcyc();
    check("halt_no_disp", {31'b0, dispatch}, 32'd0);
    halted = 1'b0;
    write_reg(0, 8'h00);
    instr(1, 0, 0);
    instr(0, 0, 0);
    check("halt_ime_on", {31'b0, ime}, 32'd1);
    halted = 1'b1;
    pulse_irq(5'b00100);
    exp_q.push_back('{ack: 5'b00100, vec: 8'h50});
    mcyc();
    check("halt_disp", {31'b0, dispatch}, 32'd1);
    halted = 1'b0;
    repeat (5) mcyc();

    // Re-request on the ack CLK keeps IF[1] set.
    instr(1, 0, 0);
    instr(0, 0, 0);
    write_reg(1, 8'h02);
    pulse_irq(5'b00010);
    exp_q.push_back('{ack: 5'b00010, vec: 8'h48});
    instr(0, 0, 0);
    repeat (3) mcyc();
    mcyc(5'b00010);
    read_reg(0, rd); check("if1_rerequest", {24'b0, rd}, 32'hE2);
    mcyc();

    // Reset during D3.
    instr(1, 0, 0);
    instr(0, 0, 0);
    mcyc(); mcyc();
    check("in_d3", {29'b0, disp_state}, 32'd3);
    RESET = 1'b1;
    tick();
    check("rst_mid_state", {29'b0, disp_state}, 32'd0);
    check("rst_mid_ime", {31'b0, ime}, 32'd0);
    check("rst_mid_vec", {24'b0, int_vector}, 32'h00);
    read_reg(1, rd); check("rst_mid_ie", {24'b0, rd}, 32'h00);
    read_reg(0, rd); check("rst_mid_if", {24'b0, rd}, 32'hE0);
    RESET = 1'b0;
    tick(); tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
